// File: rtl/keypad_sequencer.sv
// keypad_sequencer: keypad digit collection, passcode check, unlock/error/alarm sequencing with lockout.
// Optional entry inactivity timeout is compiled in when KEYPAD_TIMEOUT_EN is defined.
module keypad_sequencer #(
  parameter int UNLOCK_CYCLES  = 8,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] pass_code,
  output logic [3:0]  digit4,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic        load,
  output logic        unlock,
  output logic        error,
  output logic        alarm,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  fail_cnt
);
`ifdef KEYPAD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAX_UL = UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAXC   = MAX_UL > TIMEOUT_CYCLES ? MAX_UL : TIMEOUT_CYCLES;
  localparam int TW     = MAXC > 1 ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, FAIL, LOCKOUT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [2:0]    cnt_q, cnt_d, fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          load_q, load_d, unlock_q, unlock_d, error_q, error_d, alarm_q, alarm_d;

  wire is_dig = key_valid && key_code <= 4'd9;
  wire is_clr = key_valid && key_code == 4'hA;
  wire is_ent = key_valid && key_code == 4'hB;
  wire tmr_z  = tmr_q == '0;

  assign {digit4, digit3, digit2, digit1} = entry_q;
  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;
  assign load      = load_q;
  assign unlock    = unlock_q;
  assign error     = error_q;
  assign alarm     = alarm_q;

  // next-state and next-output decode; every output is produced one edge ahead so it is registered
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    load_d   = 1'b0;
    unlock_d = 1'b0;
    error_d  = 1'b0;
    alarm_d  = 1'b0;
    case (state_q)
      IDLE: if (is_dig) begin
        state_d = ENTRY;
        entry_d = {12'h000, key_code};
        cnt_d   = 3'd1;
        tmr_d   = TW'(TIMEOUT_CYCLES - 1);
      end
      ENTRY: begin
        if (is_ent) begin
          state_d = CHECK;
          load_d  = 1'b1;
        end else if (is_clr) begin
          state_d = IDLE;
          entry_d = '0;
          cnt_d   = '0;
        end else if (is_dig) begin
          entry_d = cnt_q < 3'd4 ? {entry_q[11:0], key_code} : entry_q;
          cnt_d   = cnt_q < 3'd4 ? cnt_q + 3'd1 : cnt_q;
          tmr_d   = TW'(TIMEOUT_CYCLES - 1);
        end else if (TO_EN) begin
          state_d = tmr_z ? IDLE : ENTRY;
          entry_d = tmr_z ? '0 : entry_q;
          cnt_d   = tmr_z ? '0 : cnt_q;
          tmr_d   = tmr_z ? tmr_q : tmr_q - TW'(1);
        end
      end
      CHECK: if (cnt_q == 3'd4 && entry_q == pass_code) begin
        state_d  = GRANT;
        unlock_d = 1'b1;
        fail_d   = '0;
        tmr_d    = TW'(UNLOCK_CYCLES - 1);
      end else begin
        state_d = FAIL;
        error_d = 1'b1;
        fail_d  = fail_q >= 3'(MAX_FAIL) ? 3'(MAX_FAIL) : fail_q + 3'd1;
        entry_d = '0;
        cnt_d   = '0;
      end
      GRANT: begin
        state_d  = tmr_z ? IDLE : GRANT;
        unlock_d = !tmr_z;
        entry_d  = tmr_z ? '0 : entry_q;
        cnt_d    = tmr_z ? '0 : cnt_q;
        tmr_d    = tmr_z ? tmr_q : tmr_q - TW'(1);
      end
      FAIL: begin
        state_d = fail_q == 3'(MAX_FAIL) ? LOCKOUT : IDLE;
        alarm_d = fail_q == 3'(MAX_FAIL);
        tmr_d   = TW'(LOCKOUT_CYCLES - 1);
      end
      LOCKOUT: begin
        state_d = tmr_z ? IDLE : LOCKOUT;
        alarm_d = !tmr_z;
        fail_d  = tmr_z ? '0 : fail_q;
        tmr_d   = tmr_z ? tmr_q : tmr_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, cleared asynchronously so reset aborts any unlock or alarm at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      tmr_q    <= '0;
      load_q   <= 1'b0;
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      load_q   <= load_d;
      unlock_q <= unlock_d;
      error_q  <= error_d;
      alarm_q  <= alarm_d;
    end
  end
endmodule

// File: tb/tb_keypad_sequencer.sv
// tb_keypad_sequencer: directed keypad sessions checked against a timeline model of the sequencer.
module tb_keypad_sequencer;
  localparam int U = 8, MF = 3, L = 16, T = 32;

  logic clk = 1'b0, reset = 1'b1, key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [15:0] pass_code = 16'h1234;
  logic [3:0] digit4, digit3, digit2, digit1;
  logic load, unlock, error, alarm;
  logic [2:0] digit_cnt, fail_cnt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  keypad_sequencer #(.UNLOCK_CYCLES(U), .MAX_FAIL(MF), .LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .pass_code(pass_code),
    .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .load(load), .unlock(unlock), .error(error), .alarm(alarm),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted ENTER at edge e fixes the whole outcome schedule.
  int n, e, free_at, clr_at, f1_at, f1_val, f2_at, fails, last_key;
  bit grant, lock, took;
  int q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; e = -1000; free_at = 0; clr_at = -1; f1_at = -1; f1_val = 0; f2_at = -1;
      fails = 0; last_key = 0; grant = 0; lock = 0; q.delete();
    end else begin
      n++;
      took = 0;
      if (n == clr_at) q.delete();
      if (n == f1_at) fails = f1_val;
      if (n == f2_at) fails = 0;
      if (n >= free_at && key_valid) begin
        if (key_code <= 9) begin
          if (q.size() < 4) q.push_back(int'(key_code));
          last_key = n;
          took = 1;
        end else if (key_code == 10) begin
          q.delete();
          took = 1;
        end else if (key_code == 11 && q.size() > 0) begin
          e = n;
          grant = q.size() == 4 && (q[0] * 4096 + q[1] * 256 + q[2] * 16 + q[3]) == int'(pass_code);
          lock = !grant && fails + 1 >= MF;
          clr_at = grant ? e + U + 1 : e + 1;
          f1_at = e + 1;
          f1_val = grant ? 0 : (fails + 1 > MF ? MF : fails + 1);
          f2_at = lock ? e + L + 2 : -1;
          free_at = grant ? e + U + 2 : (lock ? e + L + 3 : e + 3);
          took = 1;
        end
      end
`ifdef KEYPAD_TIMEOUT_EN
      if (!took && n >= free_at && q.size() > 0 && n - last_key >= T) q.delete();
`endif
    end
  end

  function automatic logic [31:0] model_out();
    logic [15:0] d = '0;
    for (int i = 0; i < q.size(); i++) d = {d[11:0], 4'(q[i])};
    return {6'd0, d, n == e, grant && n >= e + 1 && n <= e + U, !grant && n == e + 1,
            lock && n >= e + 2 && n <= e + L + 1, 3'(q.size()), 3'(fails)};
  endfunction

  always @(negedge clk)
    if (!reset)
      chk("cycle", {6'd0, digit4, digit3, digit2, digit1, load, unlock, error, alarm, digit_cnt, fail_cnt}, model_out());

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    int cnt, errs;
    idle(2);
    #1 chk("reset_outs", {digit4, digit3, digit2, digit1, load, unlock, error, alarm, digit_cnt, fail_cnt}, 0);
    reset = 1'b0;
    idle(2);
    code(1, 2, 3, 4); press(11);
    chk("load_hi", load, 1);
    chk("load_digits", {digit4, digit3, digit2, digit1}, 16'h1234);
    cnt = 0; errs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt += int'(unlock);
      errs += int'(error);
    end
    chk("unlock_len", cnt, U);
    chk("grant_no_err", errs, 0);
    chk("grant_fail_cnt", fail_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      code(9, 9, 9, 9); press(11);
      @(negedge clk);
      chk("fail_err", error, 1);
      chk("fail_cnt_step", fail_cnt, i + 1);
    end
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      cnt += int'(alarm);
      key_valid = j < 10;
      key_code = 4'd5;
    end
    chk("alarm_len", cnt, L);
    chk("lockout_fail_clr", fail_cnt, 0);
    chk("lockout_keys_ign", digit_cnt, 0);
    press(1); press(2); press(11);
    @(negedge clk);
    chk("short_err", error, 1);
    chk("short_fail_cnt", fail_cnt, 1);
    idle(2);
    code(1, 2, 3, 4); press(5); press(11);
    chk("ovf_digits", {digit4, digit3, digit2, digit1}, 16'h1234);
    @(negedge clk);
    chk("ovf_unlock", unlock, 1);
    chk("ovf_fail_clr", fail_cnt, 0);
    idle(12);
    press(14);
    chk("ign_idle", digit_cnt, 0);
    press(1); press(2); press(10);
    chk("clear_cnt", digit_cnt, 0);
    chk("clear_digits", {digit4, digit3, digit2, digit1}, 0);
    press(1); press(14); press(2); press(3); press(4);
    chk("ign_entry", digit_cnt, 4);
    press(11);
    chk("clr_digits", {digit4, digit3, digit2, digit1}, 16'h1234);
    @(negedge clk);
    chk("clr_unlock", unlock, 1);
    idle(12);
    code(1, 2, 3, 4); press(11);
    idle(3);
    chk("pre_rst_unlock", unlock, 1);
    #2 reset = 1'b1;
    #1 chk("midrst_outs", {digit4, digit3, digit2, digit1, load, unlock, error, alarm, digit_cnt, fail_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    code(1, 2, 3, 4); press(11);
    @(negedge clk);
    chk("post_rst_unlock", unlock, 1);
    idle(12);
`ifdef KEYPAD_TIMEOUT_EN
    press(1);
    idle(T - 1);
    chk("to_before", digit_cnt, 1);
    @(negedge clk);
    chk("to_cnt", digit_cnt, 0);
    chk("to_digits", {digit4, digit3, digit2, digit1}, 0);
    chk("to_no_err", {error, fail_cnt}, 0);
    idle(2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_sequencer.md
# keypad_sequencer

Sequencer for the door security datapath. It collects keypad digits into a four-digit entry and drives the digit/load inputs of the four-digit result register. It compares the entry against the stored passcode and drives the unlock, error and alarm outputs, including a lockout after repeated failures. It sits between the keypad decoder and the result register / door actuator.

## Interface
- UNLOCK_CYCLES, 8: cycles `unlock` is held after a correct code (≥1).
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (1–7).
- LOCKOUT_CYCLES, 16: cycles `alarm` is held in lockout (≥1).
- TIMEOUT_CYCLES, 32: inactivity limit during entry. Used only when `KEYPAD_TIMEOUT_EN` is defined.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- key_valid  in  1  one-cycle strobe; `key_code` is valid while high.
- key_code  in  4  0–9 digit, 0xA CLEAR, 0xB ENTER, 0xC–0xF ignored.
- pass_code  in  16  stored code {d4,d3,d2,d1}, BCD; quasi-static.
- digit4, digit3, digit2, digit1  out  4 each  assembled entry; digit4 is the first key entered.
- load  out  1  one-cycle strobe to the result register.
- unlock  out  1  door release.
- error  out  1  one-cycle pulse on a failed attempt.
- alarm  out  1  high during lockout.
- digit_cnt  out  3  digits entered so far (0–4).
- fail_cnt  out  3  consecutive failures.

## Operation
- States: IDLE, ENTRY, CHECK, GRANT, FAIL, LOCKOUT.
- All outputs are registered. Reset value is 0 for every output; state resets to IDLE.
- IDLE:
  - A digit key loads into digit1 and sets digit_cnt=1, then moves to ENTRY.
  - CLEAR and ENTER are ignored.
- ENTRY, digit key:
  - If digit_cnt<4: shift digit4←digit3←digit2←digit1←key and increment digit_cnt.
  - If digit_cnt=4: the key is ignored (no overwrite).
- ENTRY, CLEAR: zero all digits, set digit_cnt=0, go to IDLE. fail_cnt is unchanged.
- ENTRY, ENTER: go to CHECK. An entry with digit_cnt<4 is still checked and always fails.
- CHECK (one cycle):
  - load=1.
  - Match = (digit_cnt==4) && ({digit4,digit3,digit2,digit1}==pass_code).
  - On match go to GRANT; otherwise go to FAIL.
- GRANT:
  - unlock=1 for UNLOCK_CYCLES cycles.
  - fail_cnt=0 on entry.
  - On exit, clear digits and digit_cnt and go to IDLE.
- FAIL (one cycle):
  - error=1; fail_cnt+1 (saturates at MAX_FAIL); clear digits and digit_cnt.
  - If the new fail_cnt==MAX_FAIL go to LOCKOUT; otherwise go to IDLE.
- LOCKOUT:
  - alarm=1 for LOCKOUT_CYCLES cycles.
  - On exit, fail_cnt=0 and go to IDLE.
- key_valid is ignored in CHECK, GRANT, FAIL and LOCKOUT. Key codes 0xC–0xF are ignored in all states.
- load is asserted only in CHECK.
- digit outputs hold their value through CHECK so the register captures the entry.
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0. Any unlock or alarm in progress is aborted.

## Timing
- Key accepted at edge N → digit and digit_cnt update visible after edge N.
- ENTER at edge N:
  - CHECK / load high in cycle N+1.
  - unlock or error high from cycle N+2.
  - Total ENTER→unlock latency: 2 cycles.
- unlock stays high for exactly UNLOCK_CYCLES consecutive cycles.
- alarm stays high for exactly LOCKOUT_CYCLES consecutive cycles, beginning the cycle after error.
- The first key is accepted in the cycle after the GRANT or LOCKOUT exit.
- Internal timer width: clog2 of the largest cycle parameter. The timer reloads on each state entry.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - In ENTRY, the inactivity counter resets on every accepted key.
  - After TIMEOUT_CYCLES cycles with no key, clear digits and digit_cnt and go to IDLE.
  - A timeout is not a failure: no error pulse and fail_cnt is unchanged.
  - ENTER in the same cycle as expiry takes precedence over the timeout.
- Undefined: no timeout logic; ENTRY waits indefinitely.

## Test plan
- Correct code: pass_code=16'h1234; keys 1,2,3,4,ENTER → load one cycle with digits 1/2/3/4, then unlock high for 8 cycles, error=0, fail_cnt=0.
- Lockout: three wrong entries (9,9,9,9,ENTER) → three error pulses, fail_cnt 1,2,3, then alarm for 16 cycles. Keys pressed during alarm are ignored. fail_cnt=0 afterwards.
- Short entry and overflow:
  - 1,2,ENTER → error and fail_cnt=1.
  - 1,2,3,4,5,ENTER → digits remain 1/2/3/4 and unlock is asserted.
- CLEAR: 1,2,CLEAR,1,2,3,4,ENTER → unlock. Also verify the 0xE key is ignored.
- Reset mid-GRANT, 3 cycles into unlock → all outputs 0 immediately, state IDLE. Next entry is accepted normally.
- With `KEYPAD_TIMEOUT_EN`: key 1 then 32 idle cycles → digits cleared, digit_cnt=0, no error.
